// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, opcodes, funct3 codes, ALU ops and FSM states
// Contents: bus width localparams, RV32I opcode/funct3 constants, alu_op_t,
// state_t and alu_op_decode() which maps an instruction onto an ALU operation.
package cpu_pkg;

  localparam int IBUS_ADDR_WIDTH = 32;
  localparam int IBUS_DATA_WIDTH = 32;
  localparam int DBUS_ADDR_WIDTH = 32;
  localparam int DBUS_DATA_WIDTH = 32;
  localparam int DBUS_STRB_WIDTH = 4;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6f;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;

  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;

  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
    ALU_OR, ALU_AND, ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU
  } alu_op_t;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;

  // alt is instruction bit 30: selects SUB (register form only) and SRA/SRAI.
  function automatic alu_op_t alu_op_decode(input logic [6:0] opcode,
                                            input logic [2:0] f3,
                                            input logic alt);
    alu_op_t op;
    op = ALU_ADD;
    if (opcode == OPC_BRANCH) begin
      case (f3)
        F3_BEQ:  op = ALU_BEQ;
        F3_BNE:  op = ALU_BNE;
        F3_BLT:  op = ALU_BLT;
        F3_BGE:  op = ALU_BGE;
        F3_BLTU: op = ALU_BLTU;
        F3_BGEU: op = ALU_BGEU;
        default: op = ALU_ADD;  // reserved branch codes never take
      endcase
    end else begin
      case (f3)
        F3_ADD:  op = (opcode == OPC_OP && alt) ? ALU_SUB : ALU_ADD;
        F3_SLL:  op = ALU_SLL;
        F3_SLT:  op = ALU_SLT;
        F3_SLTU: op = ALU_SLTU;
        F3_XOR:  op = ALU_XOR;
        F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
        F3_OR:   op = ALU_OR;
        default: op = ALU_AND;
      endcase
    end
    return op;
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// rtl/cpu_alu.sv - combinational RV32I ALU and branch comparator
// Ports: op (alu_op_t), a, b (operands) -> result (arith/logic value),
// taken (branch condition, only meaningful for ALU_B* ops).
module cpu_alu
  import cpu_pkg::*;
(
  input  alu_op_t     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        taken
);

  always_comb begin
    result = '0;
    taken  = 1'b0;
    case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLL:  result = a << b[4:0];
      ALU_SLT:  result = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: result = {31'b0, a < b};
      ALU_XOR:  result = a ^ b;
      ALU_SRL:  result = a >> b[4:0];
      ALU_SRA:  result = $signed(a) >>> b[4:0];
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      ALU_BEQ:  taken = (a == b);
      ALU_BNE:  taken = (a != b);
      ALU_BLT:  taken = ($signed(a) < $signed(b));
      ALU_BGE:  taken = ($signed(a) >= $signed(b));
      ALU_BLTU: taken = (a < b);
      ALU_BGEU: taken = (a >= b);
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/cpu.sv
// rtl/cpu.sv - multicycle RV32I core: FETCH -> DECODE -> EXEC -> [MEM -> [WB]]
// Ports: clk_i, rst_i (sync active-high), stall_i (freeze);
// ibus_araddr_o/ibus_rdata_i (sync instruction memory, 1-cycle latency);
// dbus_addr_o, dbus_wvalid_o, dbus_wdata_o, dbus_wstrb_o, dbus_rdata_i (data bus).
module cpu
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       stall_i,
  output logic [IBUS_ADDR_WIDTH-1:0] ibus_araddr_o,
  input  logic [IBUS_DATA_WIDTH-1:0] ibus_rdata_i,
  output logic [DBUS_ADDR_WIDTH-1:0] dbus_addr_o,
  output logic                       dbus_wvalid_o,
  output logic [DBUS_DATA_WIDTH-1:0] dbus_wdata_o,
  output logic [DBUS_STRB_WIDTH-1:0] dbus_wstrb_o,
  input  logic [DBUS_DATA_WIDTH-1:0] dbus_rdata_i
);

  state_t      state;
  logic [31:0] pc, ir;
  logic [31:0] rf [32];

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] rs1_val, rs2_val;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        is_load, is_store;
  logic [31:0] mem_addr, pc_plus4, jalr_sum;

  assign opcode   = ir[6:0];
  assign rd       = ir[11:7];
  assign f3       = ir[14:12];
  assign rs1      = ir[19:15];
  assign rs2      = ir[24:20];
  assign rs1_val  = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
  assign rs2_val  = (rs2 == 5'd0) ? 32'd0 : rf[rs2];
  assign imm_i    = {{20{ir[31]}}, ir[31:20]};
  assign imm_s    = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b    = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_u    = {ir[31:12], 12'b0};
  assign imm_j    = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
  assign is_load  = (opcode == OPC_LOAD);
  assign is_store = (opcode == OPC_STORE);
  // IR and the register file are frozen through MEM/WB, so this stays constant there.
  assign mem_addr = rs1_val + (is_store ? imm_s : imm_i);
  assign pc_plus4 = pc + 32'd4;
  assign jalr_sum = rs1_val + imm_i;

  alu_op_t     alu_op;
  logic [31:0] alu_b, alu_result;
  logic        alu_taken;

  assign alu_op = alu_op_decode(opcode, f3, ir[30]);
  assign alu_b  = (opcode == OPC_OP || opcode == OPC_BRANCH) ? rs2_val : imm_i;

  cpu_alu u_alu (
    .op     (alu_op),
    .a      (rs1_val),
    .b      (alu_b),
    .result (alu_result),
    .taken  (alu_taken)
  );

  logic [31:0] next_pc, exec_wdata;
  logic        exec_we;

  always_comb begin
    next_pc    = pc_plus4;
    exec_wdata = alu_result;
    exec_we    = 1'b0;
    case (opcode)
      OPC_LUI:    begin exec_we = 1'b1; exec_wdata = imm_u; end
      OPC_AUIPC:  begin exec_we = 1'b1; exec_wdata = pc + imm_u; end
      OPC_JAL:    begin exec_we = 1'b1; exec_wdata = pc_plus4; next_pc = pc + imm_j; end
      OPC_JALR:   begin exec_we = 1'b1; exec_wdata = pc_plus4; next_pc = jalr_sum & ~32'd1; end
      OPC_BRANCH: if (alu_taken) next_pc = pc + imm_b;
      OPC_OPIMM,
      OPC_OP:     exec_we = 1'b1;
      default:    exec_we = 1'b0;  // FENCE/SYSTEM/unknown behave as NOP
    endcase
  end

  // Load lane selection: byte by addr[1:0], half by addr[1]; misalignment not trapped.
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_data;

  assign ld_byte = dbus_rdata_i[{mem_addr[1:0], 3'b000} +: 8];
  assign ld_half = dbus_rdata_i[{mem_addr[1], 4'b0000} +: 16];

  always_comb begin
    case (f3)
      F3_B:    load_data = {{24{ld_byte[7]}}, ld_byte};
      F3_H:    load_data = {{16{ld_half[15]}}, ld_half};
      F3_BU:   load_data = {24'd0, ld_byte};
      F3_HU:   load_data = {16'd0, ld_half};
      default: load_data = dbus_rdata_i;
    endcase
  end

  logic        rf_we;
  logic [31:0] rf_wdata;

  assign rf_we    = !rst_i && !stall_i && (rd != 5'd0) &&
                    ((state == S_EXEC && exec_we) || state == S_WB);
  assign rf_wdata = (state == S_WB) ? load_data : exec_wdata;

  always_ff @(posedge clk_i) begin
    if (rf_we) rf[rd] <= rf_wdata;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_FETCH;
      pc    <= RESET_PC;
      ir    <= NOP_INSN;
    end else if (!stall_i) begin
      case (state)
        S_FETCH:  state <= S_DECODE;
        S_DECODE: begin ir <= ibus_rdata_i; state <= S_EXEC; end
        S_EXEC: begin
          if (is_load || is_store) state <= S_MEM;
          else begin pc <= next_pc; state <= S_FETCH; end
        end
        S_MEM: begin
          if (is_load) state <= S_WB;
          else begin pc <= pc_plus4; state <= S_FETCH; end
        end
        S_WB:     begin pc <= pc_plus4; state <= S_FETCH; end
        default:  state <= S_FETCH;
      endcase
    end
  end

  logic in_mem;
  assign in_mem        = (state == S_MEM) || (state == S_WB);
  assign ibus_araddr_o = pc;
  assign dbus_addr_o   = in_mem ? mem_addr : 32'd0;
  // Gated by stall and reset so a held or aborted store never reaches memory.
  assign dbus_wvalid_o = (state == S_MEM) && is_store && !stall_i && !rst_i;

  always_comb begin
    dbus_wdata_o = '0;
    dbus_wstrb_o = '0;
    if (dbus_wvalid_o) begin
      case (f3)
        F3_B: begin
          dbus_wdata_o = {4{rs2_val[7:0]}};
          dbus_wstrb_o = 4'b0001 << mem_addr[1:0];
        end
        F3_H: begin
          dbus_wdata_o = {2{rs2_val[15:0]}};
          dbus_wstrb_o = mem_addr[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          dbus_wdata_o = rs2_val;
          dbus_wstrb_o = 4'b1111;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu.sv
// tb/tb_cpu.sv - directed self-checking bench for cpu
module tb_cpu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic [31:0] ibus_araddr, ibus_rdata, dbus_addr, dbus_wdata, dbus_rdata;
  logic        dbus_wvalid;
  logic [3:0]  dbus_wstrb;

  int total = 0;
  int bad = 0;

  logic [31:0] imem [64];
  logic [31:0] dmem [64];
  logic        mem_clr = 1'b0;
  int          st_cnt;
  logic [31:0] st_addr [4];
  logic [31:0] st_data [4];
  logic [3:0]  st_strb [4];
  logic [31:0] pat = 32'hAACCE2F0;
  int          pat_idx = 0;

  cpu #(.RESET_PC(32'h0)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .stall_i       (stall),
    .ibus_araddr_o (ibus_araddr),
    .ibus_rdata_i  (ibus_rdata),
    .dbus_addr_o   (dbus_addr),
    .dbus_wvalid_o (dbus_wvalid),
    .dbus_wdata_o  (dbus_wdata),
    .dbus_wstrb_o  (dbus_wstrb),
    .dbus_rdata_i  (dbus_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    ibus_rdata <= imem[ibus_araddr[7:2]];
    dbus_rdata <= dmem[dbus_addr[7:2]];
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) dmem[i] <= 32'd0;
      st_cnt <= 0;
    end else if (dbus_wvalid) begin
      for (int b = 0; b < 4; b++)
        if (dbus_wstrb[b]) dmem[dbus_addr[7:2]][8*b +: 8] <= dbus_wdata[8*b +: 8];
      if (st_cnt < 4) begin
        st_addr[st_cnt] <= dbus_addr;
        st_data[st_cnt] <= dbus_wdata;
        st_strb[st_cnt] <= dbus_wstrb;
      end
      st_cnt <= st_cnt + 1;
    end
  end

  function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, int op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] enc_s(int imm, int rs2, int rs1, int f3);
    return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_u(int imm20, int rd, int op);
    return {imm20[19:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] enc_j(int imm, int rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6f};
  endfunction
  function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
  endfunction

  task automatic clear_imem();
    for (int i = 0; i < 64; i++) imem[i] = 32'h0000_0013;
  endtask

  task automatic load_prog_a();
    clear_imem();
    imem[0] = enc_u(32'h10000, 10, 7'h37);
    imem[1] = enc_i(5, 0, 0, 1, 7'h13);
    imem[2] = enc_i(7, 1, 0, 2, 7'h13);
    imem[3] = enc_s(0, 2, 10, 2);
    imem[4] = enc_i(32'h0AB, 0, 0, 3, 7'h13);
    imem[5] = enc_s(3, 3, 10, 0);
    imem[6] = enc_i(3, 10, 0, 4, 7'h03);
    imem[7] = enc_i(3, 10, 4, 5, 7'h03);
    imem[8] = enc_j(0, 0);
  endtask

  task automatic do_reset();
    stall = 1'b0;
    rst = 1'b1;
    mem_clr = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    mem_clr = 1'b0;
  endtask

  task automatic run_cycles(input int n, input bit use_pat);
    for (int i = 0; i < n; i++) begin
      stall = use_pat ? pat[pat_idx] : 1'b0;
      pat_idx = (pat_idx + 1) % 32;
      @(posedge clk);
      #1;
    end
    stall = 1'b0;
  endtask

  task automatic check_prog_a(input string tag);
    total++; if (dut.rf[1] !== 32'd5) begin bad++; $display("FAIL %s_x1 got=%h exp=%h", tag, dut.rf[1], 32'd5); end
    total++; if (dut.rf[2] !== 32'd12) begin bad++; $display("FAIL %s_x2 got=%h exp=%h", tag, dut.rf[2], 32'd12); end
    total++; if (dut.rf[10] !== 32'h1000_0000) begin bad++; $display("FAIL %s_x10 got=%h exp=%h", tag, dut.rf[10], 32'h1000_0000); end
    total++; if (dut.rf[4] !== 32'hFFFF_FFAB) begin bad++; $display("FAIL %s_lb got=%h exp=%h", tag, dut.rf[4], 32'hFFFF_FFAB); end
    total++; if (dut.rf[5] !== 32'h0000_00AB) begin bad++; $display("FAIL %s_lbu got=%h exp=%h", tag, dut.rf[5], 32'h0000_00AB); end
    total++; if (st_cnt !== 2) begin bad++; $display("FAIL %s_store_count got=%0d exp=2", tag, st_cnt); end
    total++; if (st_addr[0] !== 32'h1000_0000 || st_data[0] !== 32'h0000_000C || st_strb[0] !== 4'b1111) begin
      bad++; $display("FAIL %s_sw got=%h/%h/%b exp=10000000/0000000c/1111", tag, st_addr[0], st_data[0], st_strb[0]); end
    total++; if (st_addr[1] !== 32'h1000_0003 || st_data[1] !== 32'hABAB_ABAB || st_strb[1] !== 4'b1000) begin
      bad++; $display("FAIL %s_sb got=%h/%h/%b exp=10000003/abababab/1000", tag, st_addr[1], st_data[1], st_strb[1]); end
    total++; if (ibus_araddr !== 32'h20) begin bad++; $display("FAIL %s_halt_pc got=%h exp=%h", tag, ibus_araddr, 32'h20); end
  endtask

  task automatic test_reset();
    clear_imem();
    stall = 1'b0;
    rst = 1'b1;
    mem_clr = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (ibus_araddr !== 32'h0) begin bad++; $display("FAIL reset_araddr got=%h exp=0", ibus_araddr); end
    total++; if (dbus_wvalid !== 1'b0) begin bad++; $display("FAIL reset_wvalid got=%b exp=0", dbus_wvalid); end
    total++; if (dbus_addr !== 32'h0 || dbus_wdata !== 32'h0 || dbus_wstrb !== 4'h0) begin
      bad++; $display("FAIL reset_dbus got=%h/%h/%b exp=0/0/0", dbus_addr, dbus_wdata, dbus_wstrb); end
    rst = 1'b0;
    mem_clr = 1'b0;
    @(negedge clk);
    total++; if (ibus_araddr !== 32'h0) begin bad++; $display("FAIL first_fetch got=%h exp=0", ibus_araddr); end
    // one NOP takes FETCH/DECODE/EXEC: three edges after release the PC reads 4
    repeat (3) @(negedge clk);
    total++; if (ibus_araddr !== 32'h4) begin bad++; $display("FAIL nop_pc got=%h exp=4", ibus_araddr); end
  endtask

  task automatic test_store_load();
    load_prog_a();
    do_reset();
    run_cycles(60, 1'b0);
    check_prog_a("plain");
  endtask

  task automatic test_alu();
    clear_imem();
    imem[0] = enc_i(32'hFFFFFFF8, 0, 0, 1, 7'h13);
    imem[1] = enc_i(2, 0, 0, 2, 7'h13);
    imem[2] = enc_r(32'h20, 2, 1, 5, 3);
    imem[3] = enc_r(0, 2, 1, 5, 4);
    imem[4] = enc_r(0, 2, 1, 2, 5);
    imem[5] = enc_r(0, 2, 1, 3, 6);
    imem[6] = enc_r(32'h20, 1, 2, 0, 7);
    imem[7] = enc_j(0, 0);
    do_reset();
    run_cycles(40, 1'b0);
    total++; if (dut.rf[3] !== 32'hFFFF_FFFE) begin bad++; $display("FAIL sra got=%h exp=fffffffe", dut.rf[3]); end
    total++; if (dut.rf[4] !== 32'h3FFF_FFFE) begin bad++; $display("FAIL srl got=%h exp=3ffffffe", dut.rf[4]); end
    total++; if (dut.rf[5] !== 32'd1) begin bad++; $display("FAIL slt got=%h exp=1", dut.rf[5]); end
    total++; if (dut.rf[6] !== 32'd0) begin bad++; $display("FAIL sltu got=%h exp=0", dut.rf[6]); end
    total++; if (dut.rf[7] !== 32'd10) begin bad++; $display("FAIL sub got=%h exp=a", dut.rf[7]); end
  endtask

  task automatic test_control();
    clear_imem();
    imem[0]  = enc_i(0, 0, 0, 7, 7'h13);
    imem[1]  = enc_i(1, 0, 0, 6, 7'h13);
    imem[2]  = enc_b(8, 0, 6, 0);
    imem[3]  = enc_i(2, 0, 0, 7, 7'h13);
    imem[4]  = enc_b(8, 6, 6, 0);
    imem[5]  = enc_i(99, 0, 0, 7, 7'h13);
    imem[6]  = enc_i(32'h31, 0, 0, 9, 7'h13);
    imem[7]  = enc_i(1, 0, 0, 0, 7'h13);
    imem[8]  = enc_j(8, 1);
    imem[9]  = enc_i(77, 0, 0, 1, 7'h13);
    imem[10] = enc_i(0, 9, 0, 13, 7'h67);
    imem[11] = enc_i(55, 0, 0, 13, 7'h13);
    imem[12] = enc_j(0, 0);
    do_reset();
    run_cycles(70, 1'b0);
    total++; if (dut.rf[7] !== 32'd2) begin bad++; $display("FAIL branch got=%h exp=2", dut.rf[7]); end
    total++; if (dut.rf[1] !== 32'h24) begin bad++; $display("FAIL jal_link got=%h exp=24", dut.rf[1]); end
    total++; if (dut.rf[13] !== 32'h2C) begin bad++; $display("FAIL jalr_link got=%h exp=2c", dut.rf[13]); end
    total++; if (dut.rf[0] !== 32'd0) begin bad++; $display("FAIL x0 got=%h exp=0", dut.rf[0]); end
    total++; if (ibus_araddr !== 32'h30) begin bad++; $display("FAIL jalr_target got=%h exp=30", ibus_araddr); end
  endtask

  task automatic test_stall_pattern();
    load_prog_a();
    do_reset();
    pat_idx = 0;
    run_cycles(160, 1'b1);
    run_cycles(10, 1'b0);
    check_prog_a("stall");
  endtask

  // Bring the sw (PC 0x0C) into MEM, then freeze it there.
  task automatic park_store_in_mem(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (ibus_araddr == 32'h0C) ok = 1'b1;
    end
    total++; if (!ok) begin bad++; $display("FAIL wait_sw got=%h exp=c", ibus_araddr); end
    if (ok) begin
      repeat (3) @(posedge clk);
      #1;
      stall = 1'b1;
    end
  endtask

  task automatic test_stalled_store();
    bit ok;
    load_prog_a();
    do_reset();
    park_store_in_mem(ok);
    if (ok) begin
      repeat (3) begin
        @(negedge clk);
        total++; if (dbus_wvalid !== 1'b0 || dbus_addr !== 32'h1000_0000) begin
          bad++; $display("FAIL stalled_mem got=%b/%h exp=0/10000000", dbus_wvalid, dbus_addr); end
      end
      stall = 1'b0;
      run_cycles(6, 1'b0);
      total++; if (st_cnt !== 1 || st_data[0] !== 32'h0000_000C) begin
        bad++; $display("FAIL stall_release got=%0d/%h exp=1/0000000c", st_cnt, st_data[0]); end
    end
  endtask

  task automatic test_reset_abort();
    bit ok;
    load_prog_a();
    do_reset();
    park_store_in_mem(ok);
    if (ok) begin
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      total++; if (st_cnt !== 0) begin bad++; $display("FAIL abort_store got=%0d exp=0", st_cnt); end
      total++; if (ibus_araddr !== 32'h0 || dbus_addr !== 32'h0) begin
        bad++; $display("FAIL abort_state got=%h/%h exp=0/0", ibus_araddr, dbus_addr); end
      stall = 1'b0;
      run_cycles(60, 1'b0);
      total++; if (st_cnt !== 2) begin bad++; $display("FAIL abort_rerun got=%0d exp=2", st_cnt); end
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_alu();
    test_control();
    test_stall_pattern();
    test_stalled_store();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu.md
CPU -- requirements
Module: cpu

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset: clk_i in 1 clock; rst_i in 1 synchronous active-high reset.
REQ-003 stall_i  in  1  freeze request; while 1, no architectural or FSM state changes.
REQ-004 ibus_araddr_o  out  32  instruction fetch byte address (PC).
REQ-005 ibus_rdata_i  in  32  instruction word, valid one cycle after ibus_araddr_o is presented.
REQ-006 dbus_addr_o  out  32  data byte address; map: bit28 data RAM, bit29 video RAM, bit30 perf counter.
REQ-007 dbus_wvalid_o  out  1  store strobe, one cycle per executed store.
REQ-008 dbus_wdata_o  out  32  store data, lane-replicated.
REQ-009 dbus_wstrb_o  out  4  byte enables.
REQ-010 dbus_rdata_i  in  32  load data, valid one cycle after dbus_addr_o is presented.

Function
REQ-011 ISA: RV32I integer subset: LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, LB/LH/LW/LBU/LHU, SB/SH/SW, OP-IMM, OP; FENCE/ECALL/EBREAK/unknown opcodes execute as NOP (PC+4).
REQ-012 Multicycle FSM with states FETCH -> DECODE -> EXEC -> {FETCH | MEM}; MEM -> FETCH for stores, MEM -> WB -> FETCH for loads.
REQ-013 ibus_araddr_o = PC at all times; PC changes only on leaving EXEC (non-load/store) or leaving MEM/WB.
REQ-014 DECODE: IR <= ibus_rdata_i; rs1/rs2 read from 32x32 register file.
REQ-015 EXEC: ALU/branch/jump computed; rd written for ALU, LUI, AUIPC, JAL, JALR (link = PC+4); next PC = target or PC+4; JALR target bit0 cleared.
REQ-016 x0 reads 0; writes to x0 discarded.
REQ-017 Shifts use rs2[4:0]/shamt; SLT/SLTU signed/unsigned compare; SRA arithmetic.
REQ-018 MEM/WB: dbus_addr_o = rs1+imm held constant through MEM and WB; dbus_addr_o = 0 in other states.
REQ-019 Store in MEM: dbus_wvalid_o=1 for exactly that cycle; SB wdata = byte x4, wstrb = 0001<<addr[1:0]; SH wdata = half x2, wstrb 0011 (addr[1]=0) or 1100; SW wstrb 1111.
REQ-020 Load in WB: capture dbus_rdata_i, select byte/half by addr[1:0]/addr[1], sign-extend (LB/LH) or zero-extend (LBU/LHU), write rd.
REQ-021 Misaligned accesses: no trap; lanes chosen from addr[1:0] as REQ-019/020, addr[1:0] not masked from dbus_addr_o.
REQ-022 Stall: when stall_i=1, PC, IR, regfile, FSM state hold; dbus_wvalid_o forced 0; address outputs held so synchronous memories re-present the same data.
REQ-023 A store stalled in MEM writes exactly once, on the first non-stall cycle.
REQ-024 dbus_wdata_o/dbus_wstrb_o = 0 when dbus_wvalid_o = 0.

Reset
REQ-025 rst_i=1 on a clock edge: PC<=RESET_PC, state<=FETCH, IR<=NOP (0x00000013); outputs: ibus_araddr_o=RESET_PC, dbus_wvalid_o=0, dbus_addr_o=0, dbus_wdata_o=0, dbus_wstrb_o=0.
REQ-026 rst_i has priority over stall_i; reset mid-instruction aborts it, pending store not issued.
REQ-027 Register file x1-x31 is not reset.

Structure
REQ-028 Shared header: bus widths (IBUS/DBUS_ADDR/DATA/STRB_WIDTH = 32/32/4), opcode, funct3 and ALU-op constants.
REQ-029 One sub-module cpu_alu (combinational: op, a, b -> result, branch-taken); register file and FSM in cpu.
REQ-030 clk_wiz_0 is vendor clock IP, outside this block.

Verification
REQ-031 Reset held 3 cycles -> ibus_araddr_o=0, dbus_wvalid_o=0; first fetch address 0 after release.
REQ-032 lui x10,0x10000; addi x1,x0,5; addi x2,x1,7; sw x2,0(x10) -> single pulse addr 0x10000000, wdata 0x0000000C, wstrb 1111.
REQ-033 addi x3,x0,0xAB; sb x3,3(x10); lb x4,3(x10); lbu x5,3(x10) (memory model returns stored word) -> wstrb 1000, wdata 0xABABABAB; x4=0xFFFFFFAB, x5=0x000000AB.
REQ-034 beq taken/not-taken, jal x1,+8 at PC 0x20 -> x1=0x24, PC=0x28; jalr to odd address -> bit0 cleared; addi x0,x0,1 -> x0 stays 0.
REQ-035 Rerun REQ-032/033 with stall_i driven by rotating pattern 32'hAACCE2F0 -> identical register results, exactly one wvalid pulse per store.
